// File: rtl/window3x3_stream.sv
// window3x3_stream: raster pixel stream to registered 3x3 windows using two line buffers and border masking
module window3x3_stream #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int COORD_W     = 11,
  parameter int BORDER_MODE = 0
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid_in,
  input  logic [DATA_W-1:0]     pix_in,
  output logic                  in_ready,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_out,
  output logic [COORD_W-1:0]    hc_out,
  output logic [COORD_W-1:0]    vc_out,
  output logic                  frame_done
);
  localparam int AW = $clog2(IMG_W + 1);
  localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] LAST_R = COORD_W'(IMG_H);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  logic [COORD_W-1:0] r_row, r_col;
  logic [DATA_W-1:0] r_lb1 [0:IMG_W];
  logic [DATA_W-1:0] r_lb2 [0:IMG_W];
  logic [DATA_W-1:0] r_lb1_rd, r_lb2_rd;
  logic [2:0][1:0][DATA_W-1:0] r_sa, w_base, w_sa_nxt;
  logic [2:0][2:0][DATA_W-1:0] w_cur;
  logic [2:0][DATA_W-1:0] w_col_new;
  logic [9*DATA_W-1:0] w_win;
  logic [COORD_W-1:0] w_row_eff, w_col_eff, w_row_nxt, w_col_nxt;
  logic [DATA_W-1:0] w_val;
  logic w_acc, w_proc, w_emit, w_top, w_bot, w_left, w_right;
  // frame_start forces the current position to (0,0); pad positions advance on their own
  assign w_acc     = pix_valid_in && in_ready;
  assign w_proc    = w_acc || (!in_ready && !frame_start);
  assign w_row_eff = frame_start ? '0 : r_row;
  assign w_col_eff = frame_start ? '0 : r_col;
  assign w_val     = w_acc ? pix_in : '0;
  assign w_col_nxt = !w_proc ? w_col_eff : (w_col_eff == LAST_C) ? '0 : w_col_eff + ONE;
  assign w_row_nxt = (!w_proc || w_col_eff != LAST_C) ? w_row_eff :
                     (w_row_eff == LAST_R) ? '0 : w_row_eff + ONE;
  assign w_emit    = w_proc && (w_row_eff != '0) && (w_col_eff != '0);
  assign w_top     = w_row_eff == ONE;
  assign w_bot     = w_row_eff == LAST_R;
  assign w_left    = w_col_eff == ONE;
  assign w_right   = w_col_eff == LAST_C;
  // read address runs one position ahead so read data lines up with the processed column
  always_ff @(posedge pclk) begin
    if (w_proc) begin
      r_lb1[w_col_eff[AW-1:0]] <= w_val;
      r_lb2[w_col_eff[AW-1:0]] <= r_lb1_rd;
    end
    r_lb1_rd <= r_lb1[w_col_nxt[AW-1:0]];
    r_lb2_rd <= r_lb2[w_col_nxt[AW-1:0]];
  end
  assign w_base    = frame_start ? '0 : r_sa;
  assign w_col_new = {w_val, r_lb1_rd, r_lb2_rd};
  for (genvar i = 0; i < 3; i++) begin : g_row
    assign w_cur[i]    = {w_col_new[i], w_base[i]};
    assign w_sa_nxt[i] = w_cur[i][2:1];
    for (genvar j = 0; j < 3; j++) begin : g_col
      logic [1:0] w_si, w_sj;
      assign w_si = ((i == 0 && w_top) || (i == 2 && w_bot)) ? 2'd1 : 2'(i);
      assign w_sj = ((j == 0 && w_left) || (j == 2 && w_right)) ? 2'd1 : 2'(j);
      assign w_win[(8 - 3*i - j)*DATA_W +: DATA_W] =
        (BORDER_MODE == 0 && (w_si != 2'(i) || w_sj != 2'(j))) ? '0 : w_cur[w_si][w_sj];
    end
  end
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_row      <= '0;
      r_col      <= '0;
      r_sa       <= '0;
      in_ready   <= 1'b1;
      win_valid  <= 1'b0;
      win_out    <= '0;
      hc_out     <= '0;
      vc_out     <= '0;
      frame_done <= 1'b0;
    end else begin
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_sa       <= w_proc ? w_sa_nxt : w_base;
      in_ready   <= (w_col_nxt != LAST_C) && (w_row_nxt != LAST_R);
      win_valid  <= w_emit;
      frame_done <= w_emit && w_bot && w_right;
      if (w_emit) begin
        win_out <= w_win;
        hc_out  <= w_col_eff - ONE;
        vc_out  <= w_row_eff - ONE;
      end
    end
  end
endmodule

// File: doc/window3x3_stream.md
# window3x3_stream

Streaming 3×3 neighbourhood generator for the camera filtering path. It replaces the nine-address frame-buffer read scheme with two on-chip line buffers. It accepts one raster-ordered pixel per handshake and emits one registered 3×3 window per image pixel, with configurable border handling. It sits between the frame-buffer/RGB-to-gray stage and the filtering stage, in the pclk domain, and drives window data plus centre coordinates downstream.

## Interface
Parameters:
- DATA_W, 8, bits per pixel (gray or packed colour)
- IMG_W, 640, pixels per line
- IMG_H, 480, lines per frame
- COORD_W, 11, width of coordinate outputs; must hold IMG_W and IMG_H
- BORDER_MODE, 0, 0 = zero padding, 1 = replicate nearest edge pixel

Ports:
- pclk  in  1  single clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; restarts the frame at (0,0)
- pix_valid_in  in  1  pix_in is valid
- pix_in  in  DATA_W  raster-order pixel
- in_ready  out  1  block accepts a pixel this cycle
- win_valid  out  1  win_out, hc_out and vc_out are valid
- win_out  out  9*DATA_W  taps ordered NW,N,NE,W,C,E,SW,S,SE, with NW in the MSBs
- hc_out  out  COORD_W  window centre column
- vc_out  out  COORD_W  window centre row
- frame_done  out  1  pulse with the last window of the frame

## Operation
- A pixel is accepted when pix_valid_in && in_ready. Accepted pixels fill positions (r,c) with r<IMG_H, c<IMG_W, in raster order.
- The internal position grid is (IMG_H+1)×(IMG_W+1). Pad positions are column IMG_W of every row and all of row IMG_H.
  - Pad positions are generated internally, one per cycle, with in_ready=0.
  - Pad values are written as 0.
- Position sequence:
  - After accepting (r, IMG_W-1), the next cycle processes pad (r, IMG_W), then in_ready returns to 1.
  - After pad (IMG_H-1, IMG_W), the pad row (IMG_H, 0..IMG_W) runs for IMG_W+1 consecutive cycles.
  - The block then idles with in_ready=1 at position (0,0).
- Storage:
  - Two line buffers of depth IMG_W+1 hold rows r-1 and r-2.
  - A 3×3 register array shifts one column per processed position.
- Emission: processing position (r,c) with r≥1 and c≥1 emits the window centred at (cr,cc)=(r-1,c-1).
- Border masking is applied at the output, based on the centre coordinate.
  - BORDER_MODE=0: any tap whose row or column is outside 0..IMG_H-1 / 0..IMG_W-1 outputs 0.
  - BORDER_MODE=1: tap(dr,dc) = pixel(clamp(cr+dr,0,IMG_H-1), clamp(cc+dc,0,IMG_W-1)). Corners clamp both axes.
- frame_done asserts with the window at (IMG_H-1, IMG_W-1). Exactly one window is emitted per image pixel, IMG_W*IMG_H per frame.
- frame_start, at any time:
  - Counters and the shift array clear; in_ready=1 the next cycle.
  - No window from the aborted frame is emitted afterwards.
  - Line-buffer contents need not be cleared, because masking and fill order make stale data unobservable.
- frame_start together with an accepted pixel: frame_start wins, and that pixel is taken as (0,0).
- frame_start during pad cycles: the pad sequence aborts.
- pix_valid_in gaps stall the grid; the window sequence is independent of gap pattern.

## Timing
- Reset values: in_ready=1, win_valid=0, win_out=0, hc_out=0, vc_out=0, frame_done=0. Counters are at (0,0).
- All outputs are registered.
- Latency: the window for centre (cr,cc) is valid in the cycle after position (cr+1,cc+1) is processed.
- Line buffers use a 1-cycle synchronous read; the pipeline must compensate so the stated latency holds.
- in_ready is low for exactly 1 cycle after each line's last pixel. It is low for IMG_W+2 consecutive cycles after the frame's last pixel: the pad column plus the pad row.
- With continuous pix_valid_in, one frame takes IMG_W*IMG_H + IMG_H + IMG_W + 1 cycles.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). Operation resumes at (0,0) on the first edge after release.

## Test plan
Bench parameters: IMG_W=4, IMG_H=3. Pixel value = 16*r + c.

1. **Zero mode, continuous valid.**
   - First window (0,0): C=0x00, E=0x01, S=0x10, SE=0x11, other taps 0. It arrives 1 cycle after (1,1) is accepted.
   - 12 windows total; in_ready low for 8 cycles in total.
2. **Replicate mode.**
   - Window (0,0): NW=N=W=C=0x00, NE=E=0x01, SW=S=0x10, SE=0x11.
   - Window (2,3): SE=S=E=C=0x23, NW=0x12.
3. **Random pix_valid_in gaps (30% idle).**
   - Window sequence and values are bit-identical to scenario 1.
   - No pixel is accepted while in_ready=0.
4. **frame_start after 5 accepted pixels, then a full frame.**
   - No stale window is emitted.
   - Exactly 12 correct windows follow.
5. **rst asserted mid-row, then released.**
   - All outputs are 0 and in_ready=1 during reset.
   - The following full frame produces correct windows.
6. **frame_done.**
   - Single-cycle pulse coincident with the window where hc_out=3, vc_out=2.
   - Never asserted in any other cycle.
